// File: rtl/n1_sbus_pkg.sv
// ============================================================================
// Module  : n1_sbus_pkg
// Brief   : Shared FSM state encoding and bank-select codes for the stack bus
// Revision: 1.0
// ============================================================================
`default_nettype none

package n1_sbus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Bank select codes as {tga_ps, tga_rs}
    localparam logic [1:0] BANK_PS = 2'b10;
    localparam logic [1:0] BANK_RS = 2'b01;

    function automatic logic bank_valid(input logic [1:0] tga);
        return (tga == BANK_PS) || (tga == BANK_RS);
    endfunction

endpackage

`default_nettype wire

// File: rtl/n1_sbus_target_ram.sv
// ============================================================================
// Module  : n1_sbus_target_ram
// Brief   : Single-port synchronous write-first RAM, 2^AW x DW
// Revision: 1.0
// ============================================================================
`default_nettype none

module n1_sbus_target_ram #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          clk_i,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rdata_d;
    logic [DW-1:0] rdata_q;

    always_comb begin
        rdata_d = we_i ? wdata_i : mem[addr_i];
    end

    // Output register only moves on an enabled access so it holds until consumed
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                mem[addr_i] <= wdata_i;
            end
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/n1_sbus_target.sv
// ============================================================================
// Module  : n1_sbus_target
// Brief   : Stack bus target with PS/RS banks, configurable wait states
// Revision: 1.0
// ============================================================================
`default_nettype none

module n1_sbus_target
    import n1_sbus_pkg::*;
#(
    parameter int SP_WIDTH = 12,
    parameter int MEM_AW   = 8,
    parameter int WAIT     = 0
) (
    input  logic                clk_i,
    input  logic                async_rst_i,
    input  logic                sbus_cyc_i,
    input  logic                sbus_stb_i,
    input  logic                sbus_we_i,
    input  logic [SP_WIDTH-1:0] sbus_adr_i,
    input  logic [15:0]         sbus_dat_i,
    input  logic                sbus_tga_ps_i,
    input  logic                sbus_tga_rs_i,
    output logic                sbus_ack_o,
    output logic                sbus_err_o,
    output logic                sbus_rty_o,
    output logic                sbus_stall_o,
    output logic [15:0]         sbus_dat_o,
    output logic [1:0]          prb_state_o
);

    localparam logic [2:0] WAIT_LOAD = (WAIT > 0) ? 3'(WAIT - 1) : 3'd0;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic        rerr_q, rerr_d;
    logic        ps_sel_q, ps_sel_d;
    logic [15:0] dat_q, dat_d;

    logic        accept;
    logic [1:0]  tga;
    logic        req_err;
    logic        ps_en;
    logic        rs_en;
    logic [15:0] ps_rdata;
    logic [15:0] rs_rdata;

    assign tga     = {sbus_tga_ps_i, sbus_tga_rs_i};
    assign accept  = sbus_cyc_i & sbus_stb_i & ~sbus_stall_o;
    assign req_err = ~bank_valid(tga) | ((sbus_adr_i >> MEM_AW) != '0);

    // Errored requests never touch either bank
    assign ps_en = accept & ~req_err & (tga == BANK_PS);
    assign rs_en = accept & ~req_err & (tga == BANK_RS);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        rerr_d   = rerr_q;
        ps_sel_d = ps_sel_q;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (accept) begin
                    rerr_d   = req_err;
                    ps_sel_d = (tga == BANK_PS);
                    if (WAIT == 0) begin
                        state_d = ST_RESP;
                        ack_d   = ~req_err;
                        err_d   = req_err;
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = WAIT_LOAD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (!sbus_cyc_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = 3'd0;
                end else if (cnt_q == 3'd0) begin
                    state_d = ST_RESP;
                    ack_d   = ~rerr_q;
                    err_d   = rerr_q;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // Read data comes straight from the bank register during ack, else held
    always_comb begin
        dat_d = dat_q;
        if (ack_q) begin
            dat_d = ps_sel_q ? ps_rdata : rs_rdata;
        end else if (err_q) begin
            dat_d = 16'h0000;
        end
    end

    always_ff @(posedge clk_i or negedge async_rst_i) begin
        if (!async_rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 3'd0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            rerr_q   <= 1'b0;
            ps_sel_q <= 1'b0;
            dat_q    <= 16'h0000;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            rerr_q   <= rerr_d;
            ps_sel_q <= ps_sel_d;
            dat_q    <= dat_d;
        end
    end

    n1_sbus_target_ram #(.AW(MEM_AW), .DW(16)) u_ps_ram (
        .clk_i   (clk_i),
        .en_i    (ps_en),
        .we_i    (sbus_we_i),
        .addr_i  (sbus_adr_i[MEM_AW-1:0]),
        .wdata_i (sbus_dat_i),
        .rdata_o (ps_rdata)
    );

    n1_sbus_target_ram #(.AW(MEM_AW), .DW(16)) u_rs_ram (
        .clk_i   (clk_i),
        .en_i    (rs_en),
        .we_i    (sbus_we_i),
        .addr_i  (sbus_adr_i[MEM_AW-1:0]),
        .wdata_i (sbus_dat_i),
        .rdata_o (rs_rdata)
    );

    assign sbus_ack_o   = ack_q;
    assign sbus_err_o   = err_q;
    assign sbus_rty_o   = 1'b0;
    assign sbus_stall_o = (state_q == ST_BUSY);
    assign sbus_dat_o   = dat_d;
    assign prb_state_o  = state_q;

endmodule

`default_nettype wire
